// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial arithmetic blocks.
// Includes the controller state encoding and the default datapath width.
package serial_subtractor_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bus for the serial subtractor.
//
// Handshake rules: a transfer happens on a rising clk edge where valid and
// ready are both 1. The operand side (in_valid, a, b, bin) is sampled only
// while in_ready is high. The result side (d, bout, ovf, zero) is held
// stable while out_valid is high and out_ready is low. Neither ready
// depends combinationally on its valid.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;
  logic             zero;

  // Producer/consumer side: drives operands and accepts results.
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, ovf, zero
  );

  // Subtractor side.
  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, ovf, zero
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bi, with the borrow out in bo.
// It is the mirror image of the 1-bit adder cell.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~a & bi) | (b & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: D = A - B - Bin, one bit per clock, LSB first.
// The minuend register also collects the difference. Each cycle, the bit it
// consumes leaves the LSB and the new difference bit enters at the MSB.
// After WIDTH steps, that register holds the complete difference.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEFAULT,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus,
  output state_t               dbg_state
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] d_r;
  logic             bout_r;
  logic             ovf_r;
  logic             zero_r;

  logic             cell_d;
  logic             cell_bo;
  logic             last_bit;
  logic [WIDTH-1:0] d_next;

  full_subtractor u_cell (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .bi (br),
    .d  (cell_d),
    .bo (cell_bo)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign d_next   = {cell_d, a_sr[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: accept in IDLE, step WIDTH times, and hold in DONE until the result is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.in_valid)  state_nxt = ST_RUN;
      ST_RUN:  if (last_bit)      state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, one cell step per RUN cycle, and a result/flag latch on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      d_r    <= '0;
      bout_r <= 1'b0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_sr <= bus.a;
            b_sr <= bus.b;
            br   <= bus.bin;
            cnt  <= '0;
          end
        end
        ST_RUN: begin
          a_sr <= d_next;
          b_sr <= b_sr >> 1;
          br   <= cell_bo;
          cnt  <= cnt + CNT_W'(1);
          if (last_bit) begin
            d_r    <= d_next;
            bout_r <= cell_bo;
            // br still holds the borrow into the MSB.
            ovf_r  <= br ^ cell_bo;
            zero_r <= ~|d_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.d         = d_r;
  assign bus.bout      = bout_r;
  assign bus.ovf       = ovf_r;
  assign bus.zero      = zero_r;
  assign dbg_state     = state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH=8.
// Directed corner cases, back-pressure, mid-operation reset, and random operands are
// checked against an integer-arithmetic reference model.
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  localparam int W = 8;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();
  state_t dbg_state;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on unsigned and signed views.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       output logic [W-1:0] d, output logic bout, output logic ovf,
                       output logic zero);
    int ua, ub, sa, sb, sd;
    ua   = int'(a);
    ub   = int'(b);
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    d    = W'(ua - ub - int'(bin));
    bout = (ua < ub + int'(bin));
    sd   = sa - sb - int'(bin);
    ovf  = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
    zero = (d == '0);
  endtask

  task automatic scramble();
    bus.in_valid = 1'(($urandom_range(0, 1)));
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    bus.bin      = 1'(($urandom_range(0, 1)));
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("idle_ready", 32'(bus.in_ready), 32'd1);
  endtask

  // One full transaction: issue, measure latency, hold under back-pressure, hand off.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input int hold, input bit scr);
    logic [W-1:0] ed, qd;
    logic eb, eo, ez;
    int lat;
    model(a, b, bin, ed, eb, eo, ez);
    exp_q.push_back(ed);
    wait_idle();
    bus.a = a; bus.b = b; bus.bin = bin; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (scr) scramble();
    @(negedge clk);
    check("ready_drop", 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 4 * W) begin
      @(posedge clk); #1;
      lat++;
      if (scr) scramble();
      @(negedge clk);
    end
    check("latency", 32'(lat), 32'(W));
    qd = exp_q.pop_front();
    for (int h = 0; h <= hold; h++) begin
      check("out_valid", 32'(bus.out_valid), 32'd1);
      check("in_ready_done", 32'(bus.in_ready), 32'd0);
      check("d", 32'(bus.d), 32'(qd));
      check("bout", 32'(bus.bout), 32'(eb));
      check("ovf", 32'(bus.ovf), 32'(eo));
      check("zero", 32'(bus.zero), 32'(ez));
      if (h < hold) begin
        @(posedge clk); #1;
        if (scr) scramble();
        @(negedge clk);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check("handoff_valid", 32'(bus.out_valid), 32'd0);
    check("handoff_ready", 32'(bus.in_ready), 32'd1);
    check("d_held", 32'(bus.d), 32'(qd));
    check("bout_held", 32'(bus.bout), 32'(eb));
  endtask

  initial begin
    bit seen_valid;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_d", 32'(bus.d), 32'd0);
    check("rst_flags", {29'd0, bus.bout, bus.ovf, bus.zero}, 32'd0);
    rst = 1'b0;

    // Directed corner cases.
    run_op(8'h05, 8'h03, 1'b0, 0, 1'b0);
    run_op(8'h03, 8'h05, 1'b0, 0, 1'b0);
    run_op(8'h80, 8'h01, 1'b0, 0, 1'b0);
    run_op(8'h7F, 8'hFF, 1'b0, 0, 1'b0);
    run_op(8'h10, 8'h0F, 1'b1, 0, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 0, 1'b0);

    // Back-pressure with input noise during RUN and DONE.
    run_op(8'hA5, 8'h5A, 1'b0, 5, 1'b1);

    // Reset during the 4th RUN edge discards the operation.
    wait_idle();
    bus.a = 8'h05; bus.b = 8'h03; bus.bin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_d", 32'(bus.d), 32'd0);
    check("mid_rst_flags", {29'd0, bus.bout, bus.ovf, bus.zero}, 32'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen_valid = 1'b1;
    end
    check("mid_rst_no_result", 32'(seen_valid), 32'd0);
    run_op(8'h05, 8'h03, 1'b0, 0, 1'b0);

    // Random operands, random back-pressure, and noisy inputs.
    for (int n = 0; n < 24; n++) begin
      run_op(W'($urandom), W'($urandom), 1'(($urandom_range(0, 1))),
             int'($urandom_range(0, 3)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
